// File: rtl/inst_fetch_pkg.sv
// Shared definitions for the instruction-fetch stage and the decoder.
// Holds the instruction word width and the field positions inside an instruction
// word (cond[15:14] op[13:10] rd[9:7] rs1[6:4] rs2[3:1], imm7[6:0]), plus a
// helper that sizes occupancy/credit counters for a given queue depth.
package inst_fetch_pkg;

   localparam int INST_W   = 16;

   localparam int COND_MSB = 15;
   localparam int COND_LSB = 14;
   localparam int OP_MSB   = 13;
   localparam int OP_LSB   = 10;
   localparam int RD_MSB   = 9;
   localparam int RD_LSB   = 7;
   localparam int RS1_MSB  = 6;
   localparam int RS1_LSB  = 4;
   localparam int RS2_MSB  = 3;
   localparam int RS2_LSB  = 1;
   localparam int IMM7_MSB = 6;
   localparam int IMM7_LSB = 0;

   // Counter width able to hold 0..depth inclusive.
   function automatic int cnt_w(input int depth);
      return $clog2(depth) + 1;
   endfunction

endpackage

// File: rtl/inst_fetch_if.sv
// Bundle of the fetch stage's external handshakes:
//   imem_*     : request/grant plus in-order read-data return from instruction memory
//   redirect_* : branch redirect from execute
//   inst*      : valid/ready instruction + PC toward the decoder
// Modports: master = fetch stage, slave = environment (memory, execute, decoder).
interface inst_fetch_if #(
   parameter int ADDR_W = 8
);
   import inst_fetch_pkg::*;

   logic                imem_req;
   logic [ADDR_W-1:0]   imem_addr;
   logic                imem_gnt;
   logic                imem_rvalid;
   logic [INST_W-1:0]   imem_rdata;
   logic                redirect_valid;
   logic [ADDR_W-1:0]   redirect_pc;
   logic                inst_valid;
   logic                inst_ready;
   logic [INST_W-1:0]   inst;
   logic [ADDR_W-1:0]   inst_pc;

   modport master (
      output imem_req, imem_addr, inst_valid, inst, inst_pc,
      input  imem_gnt, imem_rvalid, imem_rdata, redirect_valid, redirect_pc, inst_ready
   );

   modport slave (
      input  imem_req, imem_addr, inst_valid, inst, inst_pc,
      output imem_gnt, imem_rvalid, imem_rdata, redirect_valid, redirect_pc, inst_ready
   );

endinterface

// File: rtl/inst_fetch_fifo.sv
// Prefetch FIFO: DEPTH entries of W bits, synchronous flush, full/empty/count.
// Ports: clk, rst_n (sync, active-low), flush, push/wdata, pop/rdata, full, empty, count.
// Push and pop in the same cycle on a full FIFO is allowed; the popped slot is reused.
// Storage is not reset; only pointers and count are.
module inst_fetch_fifo
   import inst_fetch_pkg::*;
#(
   parameter int W     = 24,
   parameter int DEPTH = 2
) (
   input  logic                      clk,
   input  logic                      rst_n,
   input  logic                      flush,
   input  logic                      push,
   input  logic [W-1:0]              wdata,
   input  logic                      pop,
   output logic [W-1:0]              rdata,
   output logic                      full,
   output logic                      empty,
   output logic [cnt_w(DEPTH)-1:0]   count
);
   localparam int PW = $clog2(DEPTH);
   localparam int CW = cnt_w(DEPTH);

   logic [PW-1:0] wr_ptr_q, wr_ptr_d;
   logic [PW-1:0] rd_ptr_q, rd_ptr_d;
   logic [CW-1:0] count_q, count_d;
   logic [W-1:0]  mem_q [DEPTH];
   logic          do_push, do_pop;

   always_comb begin
      do_push  = push && !flush && (!full || pop);
      do_pop   = pop && !flush && !empty;
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      count_d  = count_q;
      if (flush) begin
         wr_ptr_d = '0;
         rd_ptr_d = '0;
         count_d  = '0;
      end else begin
         if (do_push) wr_ptr_d = wr_ptr_q + PW'(1);
         if (do_pop)  rd_ptr_d = rd_ptr_q + PW'(1);
         count_d = count_q + CW'(do_push) - CW'(do_pop);
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
      end
   end

   always_ff @(posedge clk) begin
      if (do_push) mem_q[wr_ptr_q] <= wdata;
   end

   assign rdata = mem_q[rd_ptr_q];
   assign full  = (count_q == CW'(DEPTH));
   assign empty = (count_q == '0);
   assign count = count_q;

endmodule

// File: rtl/inst_fetch.sv
// Instruction-fetch stage: owns the PC, issues word reads to instruction memory,
// buffers returned words with their PC in a prefetch FIFO and hands them to the
// decoder over valid/ready. A branch redirect restarts fetch at a new PC, clears the
// FIFO and marks every in-flight read as stale so its data is dropped on return.
// Ports: clk, rst_n (sync, active-low), bus (inst_fetch_if.master: imem request/
// response, redirect, decoder handshake).
module inst_fetch
   import inst_fetch_pkg::*;
#(
   parameter int ADDR_W   = 8,
   parameter int DEPTH    = 2,
   parameter int RESET_PC = 0
) (
   input  logic         clk,
   input  logic         rst_n,
   inst_fetch_if.master bus
);
   localparam int CW = cnt_w(DEPTH);
   localparam int PW = $clog2(DEPTH);
   localparam int EW = INST_W + ADDR_W;

   logic [ADDR_W-1:0] pc_q, pc_d;
   logic [CW-1:0]     out_q, out_d;     // reads granted, data not yet returned
   logic [CW-1:0]     disc_q, disc_d;   // of those, how many are stale
   logic [ADDR_W-1:0] pcq_q [DEPTH];    // PC of each outstanding read, oldest first
   logic [PW-1:0]     pcq_wr_q, pcq_wr_d;
   logic [PW-1:0]     pcq_rd_q, pcq_rd_d;

   logic [CW-1:0]     fifo_cnt;
   logic              fifo_full, fifo_empty;
   logic [EW-1:0]     fifo_rdata;
   logic              credit, issue, rsp, keep, pop;

   always_comb begin
      // Credit counts FIFO slots already used plus slots reserved by in-flight
      // reads (stale ones included), so a returning word always has room.
      credit   = ({1'b0, fifo_cnt} + {1'b0, out_q}) < (CW+1)'(DEPTH);
      issue    = bus.imem_req && bus.imem_gnt;
      // rvalid with nothing outstanding is a protocol error; ignore the data.
      rsp      = bus.imem_rvalid && (out_q != '0);
      keep     = rsp && !bus.redirect_valid && (disc_q == '0);
      pop      = bus.inst_valid && bus.inst_ready;

      pc_d     = pc_q;
      disc_d   = disc_q;
      pcq_wr_d = pcq_wr_q;
      pcq_rd_d = pcq_rd_q;
      if (issue) begin
         pc_d     = pc_q + ADDR_W'(1);
         pcq_wr_d = pcq_wr_q + PW'(1);
      end
      if (rsp) pcq_rd_d = pcq_rd_q + PW'(1);
      out_d = out_q + CW'(issue) - CW'(rsp);

      if (bus.redirect_valid) begin
         // Everything still in flight after this edge is stale; a word
         // returning in this very cycle is dropped right now.
         pc_d   = bus.redirect_pc;
         disc_d = out_q + CW'(issue) - CW'(rsp);
      end else if (rsp && (disc_q != '0)) begin
         disc_d = disc_q - CW'(1);
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         pc_q     <= ADDR_W'(RESET_PC);
         out_q    <= '0;
         disc_q   <= '0;
         pcq_wr_q <= '0;
         pcq_rd_q <= '0;
      end else begin
         pc_q     <= pc_d;
         out_q    <= out_d;
         disc_q   <= disc_d;
         pcq_wr_q <= pcq_wr_d;
         pcq_rd_q <= pcq_rd_d;
      end
   end

   always_ff @(posedge clk) begin
      if (issue) pcq_q[pcq_wr_q] <= pc_q;
   end

   inst_fetch_fifo #(
      .W     (EW),
      .DEPTH (DEPTH)
   ) u_fifo (
      .clk   (clk),
      .rst_n (rst_n),
      .flush (bus.redirect_valid),
      .push  (keep),
      .wdata ({bus.imem_rdata, pcq_q[pcq_rd_q]}),
      .pop   (pop),
      .rdata (fifo_rdata),
      .full  (fifo_full),
      .empty (fifo_empty),
      .count (fifo_cnt)
   );

   // Outputs are held quiet while reset is asserted and during a redirect cycle.
   assign bus.imem_req   = rst_n && !bus.redirect_valid && credit;
   assign bus.imem_addr  = bus.imem_req ? pc_q : '0;
   assign bus.inst_valid = rst_n && !bus.redirect_valid && !fifo_empty;
   assign bus.inst       = fifo_empty ? '0 : fifo_rdata[EW-1 -: INST_W];
   assign bus.inst_pc    = fifo_empty ? '0 : fifo_rdata[ADDR_W-1:0];

   a_out_bound:  assert property (@(posedge clk) disable iff (!rst_n) out_q <= CW'(DEPTH));
   a_disc_bound: assert property (@(posedge clk) disable iff (!rst_n) disc_q <= out_q);
   a_no_orphan:  assert property (@(posedge clk) disable iff (!rst_n) bus.imem_rvalid |-> (out_q != '0));
   a_no_ovf:     assert property (@(posedge clk) disable iff (!rst_n) keep |-> (!fifo_full || pop));

endmodule

// File: tb/tb_inst_fetch.sv
`timescale 1ns/1ps
module tb_inst_fetch;
   localparam int ADDR_W   = 8;
   localparam int DEPTH    = 2;
   localparam int RESET_PC = 0;

   logic clk = 1'b0;
   logic rst_n;
   always #5 clk = ~clk;

   inst_fetch_if #(.ADDR_W(ADDR_W)) bus();

   inst_fetch #(
      .ADDR_W   (ADDR_W),
      .DEPTH    (DEPTH),
      .RESET_PC (RESET_PC)
   ) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus.master)
   );

   typedef struct { logic [7:0] addr; int epoch; int due; } req_t;
   typedef struct { logic [7:0] pc; logic [15:0] data; } exp_t;

   logic [15:0] mem [256];
   req_t        pend[$];        // reads granted by memory, oldest first
   exp_t        sb[$];          // words the decoder should see next, in order
   logic [7:0]  xpc[$];         // PCs of transfers, for directed inspection
   logic [7:0]  exp_fetch_pc;
   logic [7:0]  last_pc;
   int total = 0, bad = 0;
   int cyc = 0, epoch = 0, grants = 0, xfers = 0, first_xfer_cyc = -1;
   int lat = 1, gnt_pct = 100, rdy_pct = 100;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got=%0h want=%0h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   task automatic step(input int n);
      repeat (n) begin
         @(posedge clk);
         #2;
      end
   endtask

   task automatic wait_xfer(input string name, input logic [7:0] want);
      int x0 = xfers;
      int n  = 0;
      while (xfers == x0 && n < 50) begin
         step(1);
         n++;
      end
      chk(name, (xfers != x0) ? {24'b0, last_pc} : 32'hDEAD, {24'b0, want});
   endtask

   // Memory responder + monitor. Memory inputs are driven just after the rising
   // edge; everything the DUT will act on at the next edge is observed at negedge.
   initial begin : env
      req_t r;
      exp_t e;
      logic redir;
      int   used;
      forever begin
         @(posedge clk);
         cyc++;
         #1;
         if (pend.size() > 0 && pend[0].due <= cyc) begin
            bus.imem_rvalid = 1'b1;
            bus.imem_rdata  = mem[pend[0].addr];
         end else begin
            bus.imem_rvalid = 1'b0;
            bus.imem_rdata  = 16'($urandom);
         end
         bus.imem_gnt   = ($urandom_range(99) < gnt_pct);
         bus.inst_ready = ($urandom_range(99) < rdy_pct);

         @(negedge clk);
         if (!rst_n) begin
            chk("rst_req", 32'(bus.imem_req), 32'd0);
            chk("rst_inst_valid", 32'(bus.inst_valid), 32'd0);
            pend.delete();
            sb.delete();
            epoch++;
            exp_fetch_pc = 8'(RESET_PC);
         end else begin
            redir = bus.redirect_valid;
            used  = sb.size() + pend.size();
            chk("credit_bound", 32'(used <= DEPTH), 32'd1);
            chk("imem_req", 32'(bus.imem_req), 32'(!redir && used < DEPTH));
            chk("inst_valid", 32'(bus.inst_valid), 32'(!redir && sb.size() > 0));
            if (bus.inst_valid && bus.inst_ready) begin
               if (sb.size() == 0) begin
                  chk("unexpected_xfer_pc", {24'b0, bus.inst_pc}, 32'hFFFF);
               end else begin
                  e = sb.pop_front();
                  chk("inst_pc", {24'b0, bus.inst_pc}, {24'b0, e.pc});
                  chk("inst", {16'b0, bus.inst}, {16'b0, e.data});
               end
               xfers++;
               last_pc = bus.inst_pc;
               xpc.push_back(bus.inst_pc);
               if (first_xfer_cyc < 0) first_xfer_cyc = cyc;
            end
            if (bus.imem_rvalid && pend.size() > 0) begin
               r = pend.pop_front();
               // Same-cycle response with a redirect, or any pre-redirect read, is stale.
               if (!redir && r.epoch == epoch) sb.push_back('{pc: r.addr, data: mem[r.addr]});
            end
            if (bus.imem_req && bus.imem_gnt) begin
               chk("imem_addr", {24'b0, bus.imem_addr}, {24'b0, exp_fetch_pc});
               pend.push_back('{addr: bus.imem_addr, epoch: epoch, due: cyc + lat});
               exp_fetch_pc = exp_fetch_pc + 8'd1;
               grants++;
            end
            if (redir) begin
               sb.delete();
               epoch++;
               exp_fetch_pc = bus.redirect_pc;
            end
         end
      end
   end

   initial begin : watchdog
      #500000;
      $display("FAIL watchdog: got=timeout want=finish");
      $fatal(1, "watchdog");
   end

   initial begin : main
      int   rel, g0, r;
      logic [7:0] a0;
      for (int i = 0; i < 256; i++) mem[i] = 16'($urandom);
      rst_n              = 1'b0;
      bus.imem_gnt       = 1'b0;
      bus.imem_rvalid    = 1'b0;
      bus.imem_rdata     = '0;
      bus.inst_ready     = 1'b0;
      bus.redirect_valid = 1'b0;
      bus.redirect_pc    = '0;
      step(3);

      // Reset state
      @(negedge clk);
      chk("rst_imem_addr", {24'b0, bus.imem_addr}, 32'd0);
      chk("rst_inst", {16'b0, bus.inst}, 32'd0);
      chk("rst_inst_pc", {24'b0, bus.inst_pc}, 32'd0);

      // 1: streaming from RESET_PC with 1-cycle memory
      step(1);
      rst_n = 1'b1;
      rel = cyc;
      xpc.delete();
      r = 0;
      while (xfers < 4 && r < 40) begin step(1); r++; end
      chk("t1_four_xfers", 32'(xfers >= 4), 32'd1);
      chk("t1_first_latency", 32'(first_xfer_cyc), 32'(rel + 2));
      chk("t1_pc0", {24'b0, (xpc.size() > 0) ? xpc[0] : 8'hEE}, 32'd0);
      chk("t1_pc3", {24'b0, (xpc.size() > 3) ? xpc[3] : 8'hEE}, 32'd3);

      // 2: decoder stalls; exactly DEPTH fresh reads, then request drops
      bus.redirect_valid = 1'b1;
      bus.redirect_pc    = 8'h10;
      rdy_pct            = 0;
      step(1);
      bus.redirect_valid = 1'b0;
      g0 = grants;
      step(10);
      @(negedge clk);
      chk("t2_grants", 32'(grants - g0), 32'(DEPTH));
      chk("t2_req_low", 32'(bus.imem_req), 32'd0);
      rdy_pct = 100;
      wait_xfer("t2_release_pc", 8'h10);
      step(10);

      // 3: no grant; address held, PC not advanced
      gnt_pct = 0;
      step(3);
      @(negedge clk);
      a0 = bus.imem_addr;
      for (int k = 0; k < 5; k++) begin
         step(1);
         @(negedge clk);
         chk("t3_req_held", 32'(bus.imem_req), 32'd1);
         chk("t3_addr_held", {24'b0, bus.imem_addr}, {24'b0, a0});
      end
      gnt_pct = 100;
      wait_xfer("t3_resume_pc", a0);

      // 4: latency 3, redirect with two reads in flight
      lat = 3;
      r = 0;
      while (pend.size() != 2 && r < 20) begin step(1); r++; end
      chk("t4_two_outstanding", 32'(pend.size()), 32'd2);
      bus.redirect_valid = 1'b1;
      bus.redirect_pc    = 8'h40;
      step(1);
      bus.redirect_valid = 1'b0;
      wait_xfer("t4_after_redirect", 8'h40);
      // redirect landing on a returning word
      r = 0;
      while (!bus.imem_rvalid && r < 20) begin step(1); r++; end
      chk("t4_rvalid_seen", 32'(bus.imem_rvalid), 32'd1);
      bus.redirect_valid = 1'b1;
      bus.redirect_pc    = 8'h50;
      step(1);
      bus.redirect_valid = 1'b0;
      wait_xfer("t4_coincident", 8'h50);

      // 5: PC wrap 0xFF -> 0x00
      lat = 1;
      bus.redirect_valid = 1'b1;
      bus.redirect_pc    = 8'hFE;
      step(1);
      bus.redirect_valid = 1'b0;
      xpc.delete();
      r = 0;
      while (xpc.size() < 3 && r < 40) begin step(1); r++; end
      chk("t5_xfers", 32'(xpc.size() >= 3), 32'd1);
      chk("t5_pc_fe", {24'b0, (xpc.size() > 0) ? xpc[0] : 8'hEE}, 32'hFE);
      chk("t5_pc_ff", {24'b0, (xpc.size() > 1) ? xpc[1] : 8'hEE}, 32'hFF);
      chk("t5_pc_00", {24'b0, (xpc.size() > 2) ? xpc[2] : 8'hEE}, 32'h00);

      // 6: reset with FIFO full
      rdy_pct = 0;
      step(8);
      chk("t6_fifo_full", 32'(sb.size()), 32'(DEPTH));
      rst_n = 1'b0;
      step(1);
      @(negedge clk);
      chk("t6_inst_valid", 32'(bus.inst_valid), 32'd0);
      chk("t6_req", 32'(bus.imem_req), 32'd0);
      step(1);
      rst_n   = 1'b1;
      rdy_pct = 100;
      wait_xfer("t6_restart_pc", 8'(RESET_PC));

      // Randomized traffic: memory latency/grant and decoder ready vary,
      // with sporadic redirects and resets.
      for (int i = 0; i < 3000; i++) begin
         if (i % 200 == 0) begin
            lat     = $urandom_range(1, 4);
            gnt_pct = $urandom_range(30, 100);
            rdy_pct = $urandom_range(30, 100);
         end
         r = $urandom_range(999);
         bus.redirect_valid = (r < 30);
         bus.redirect_pc    = 8'($urandom);
         rst_n              = !(r >= 30 && r < 33);
         step(1);
      end
      bus.redirect_valid = 1'b0;
      rst_n   = 1'b1;
      gnt_pct = 100;
      rdy_pct = 100;
      step(20);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
